fetch_stage: RTL and testbench

- Instruction-fetch stage of the pipelined core.
- Owns the program counter, drives the combinational instruction-memory address and captures the returned word into the IF/ID pipeline register for decode.
- Handles stalls from the hazard unit, branch redirects resolved in Execute, and decode flushes.
- Keeps fetch/bubble performance counters.

---
 rtl/core_pkg.sv | 20 ++
 rtl/pc_register.sv | 54 +++++
 rtl/fetch_stage.sv | 84 ++++++++
 tb/tb_fetch_stage.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared types and constants for the core front end
package core_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] WORD_BYTES       = 32'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
    logic        fault;
  } if_id_t;

  function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
    return pc + WORD_BYTES;
  endfunction

endpackage

// File: rtl/pc_register.sv
// rtl/pc_register.sv - program counter, next-PC selection and fetch fault flags
module pc_register
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned IMEM_AW  = 23
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_f,
  input  logic        branch_taken_e,
  input  logic [31:0] branch_target_e,
  output logic [31:0] pc_f,
  output logic [31:0] pc_plus4_f,
  output logic        fault_f
);

  logic [31:0] pc_q;
  logic [31:0] pc_next;
  logic        misalign_q;
  logic        misalign_next;
  logic        out_of_range;

  // The PC itself is always word aligned; a misaligned target is remembered
  // separately so the instruction fetched there can be tagged as faulting.
  always_comb begin
    pc_next       = pc_q;
    misalign_next = misalign_q;
    if (branch_taken_e) begin
      pc_next       = {branch_target_e[31:2], 2'b00};
      misalign_next = |branch_target_e[1:0];
    end else if (!stall_f) begin
      pc_next       = next_seq_pc(pc_q);
      misalign_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      misalign_q <= |RESET_PC[1:0];
    end else begin
      pc_q       <= pc_next;
      misalign_q <= misalign_next;
    end
  end

  assign out_of_range = (pc_q >> IMEM_AW) != 32'd0;

  assign pc_f       = pc_q;
  assign pc_plus4_f = next_seq_pc(pc_q);
  assign fault_f    = misalign_q | out_of_range;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, IF/ID register, perf counters
module fetch_stage
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned IMEM_AW  = 23
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        branch_taken_e,
  input  logic [31:0] branch_target_e,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d,
  output logic        fault_d,
  output logic [31:0] fetch_count,
  output logic [31:0] bubble_count
);

  logic [31:0] pc_f;
  logic [31:0] pc_plus4_f;
  logic        fault_f;
  logic        squash;
  if_id_t      if_id_q;
  logic [31:0] fetch_cnt_q;
  logic [31:0] bubble_cnt_q;

  pc_register #(
    .RESET_PC(RESET_PC),
    .IMEM_AW (IMEM_AW)
  ) u_pc (
    .clk            (clk),
    .reset          (reset),
    .stall_f        (stall_f),
    .branch_taken_e (branch_taken_e),
    .branch_target_e(branch_target_e),
    .pc_f           (pc_f),
    .pc_plus4_f     (pc_plus4_f),
    .fault_f        (fault_f)
  );

  assign imem_addr = pc_f;

  // A redirect always kills the wrong-path word fetched this cycle, and a
  // squash takes priority over a decode stall.
  assign squash = flush_d | branch_taken_e;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_id_q      <= '0;
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else if (squash) begin
      if_id_q.instr    <= NOP_INSTR;
      if_id_q.pc       <= pc_f;
      if_id_q.pc_plus4 <= pc_plus4_f;
      if_id_q.valid    <= 1'b0;
      if_id_q.fault    <= 1'b0;
      bubble_cnt_q     <= bubble_cnt_q + 32'd1;
    end else if (!stall_d) begin
      if_id_q.instr    <= imem_instr;
      if_id_q.pc       <= pc_f;
      if_id_q.pc_plus4 <= pc_plus4_f;
      if_id_q.valid    <= 1'b1;
      if_id_q.fault    <= fault_f;
      fetch_cnt_q      <= fetch_cnt_q + 32'd1;
    end
  end

  assign instr_d      = if_id_q.instr;
  assign pc_d         = if_id_q.pc;
  assign pc_plus4_d   = if_id_q.pc_plus4;
  assign valid_d      = if_id_q.valid;
  assign fault_d      = if_id_q.fault;
  assign fetch_count  = fetch_cnt_q;
  assign bubble_count = bubble_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed table-driven bench for fetch_stage
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall_f;
  logic        stall_d;
  logic        flush_d;
  logic        branch_taken_e;
  logic [31:0] branch_target_e;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;
  logic        fault_d;
  logic [31:0] fetch_count;
  logic [31:0] bubble_count;

  int checks = 0;
  int errors = 0;

  fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .stall_f        (stall_f),
    .stall_d        (stall_d),
    .flush_d        (flush_d),
    .branch_taken_e (branch_taken_e),
    .branch_target_e(branch_target_e),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .instr_d        (instr_d),
    .pc_d           (pc_d),
    .pc_plus4_d     (pc_plus4_d),
    .valid_d        (valid_d),
    .fault_d        (fault_d),
    .fetch_count    (fetch_count),
    .bubble_count   (bubble_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: word at byte address a holds 32'hA000_0000 + a/4.
  assign imem_instr = 32'hA000_0000 + {2'b00, imem_addr[31:2]};

  typedef struct {
    logic        sf;
    logic        sd;
    logic        fl;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic        fault;
    logic [31:0] fc;
    logic [31:0] bc;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic sf, input logic sd, input logic fl, input logic br,
                     input logic [31:0] tgt, input logic [31:0] addr,
                     input logic [31:0] instr, input logic [31:0] pc,
                     input logic valid, input logic fault,
                     input logic [31:0] fc, input logic [31:0] bc);
    vec_t v;
    v.sf = sf; v.sd = sd; v.fl = fl; v.br = br; v.tgt = tgt;
    v.addr = addr; v.instr = instr; v.pc = pc;
    v.valid = valid; v.fault = fault; v.fc = fc; v.bc = bc;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"},   imem_addr,    32'h0);
    check({tag, "_instr"},  instr_d,      32'h0);
    check({tag, "_pc"},     pc_d,         32'h0);
    check({tag, "_pc4"},    pc_plus4_d,   32'h0);
    check({tag, "_valid"},  {31'h0, valid_d}, 32'h0);
    check({tag, "_fault"},  {31'h0, fault_d}, 32'h0);
    check({tag, "_fcount"}, fetch_count,  32'h0);
    check({tag, "_bcount"}, bubble_count, 32'h0);
  endtask

  initial begin
    //  sf sd fl br  target        addr-before   instr_d        pc_d          v  f  fc  bc
    add(0, 0, 0, 0, 32'h0,        32'h0,        32'hA000_0000, 32'h0,        1, 0, 1,  0);
    add(0, 0, 0, 0, 32'h0,        32'h4,        32'hA000_0001, 32'h4,        1, 0, 2,  0);
    add(0, 0, 0, 0, 32'h0,        32'h8,        32'hA000_0002, 32'h8,        1, 0, 3,  0);
    add(0, 0, 0, 0, 32'h0,        32'hC,        32'hA000_0003, 32'hC,        1, 0, 4,  0);
    add(1, 1, 0, 0, 32'h0,        32'h10,       32'hA000_0003, 32'hC,        1, 0, 4,  0);
    add(1, 1, 0, 0, 32'h0,        32'h10,       32'hA000_0003, 32'hC,        1, 0, 4,  0);
    add(1, 1, 0, 0, 32'h0,        32'h10,       32'hA000_0003, 32'hC,        1, 0, 4,  0);
    add(0, 0, 0, 0, 32'h0,        32'h10,       32'hA000_0004, 32'h10,       1, 0, 5,  0);
    add(1, 0, 0, 1, 32'h100,      32'h14,       32'h0,         32'h14,       0, 0, 5,  1);
    add(0, 0, 0, 0, 32'h0,        32'h100,      32'hA000_0040, 32'h100,      1, 0, 6,  1);
    add(1, 1, 1, 0, 32'h0,        32'h104,      32'h0,         32'h104,      0, 0, 6,  2);
    add(0, 0, 0, 0, 32'h0,        32'h104,      32'hA000_0041, 32'h104,      1, 0, 7,  2);
    add(0, 0, 0, 1, 32'h102,      32'h108,      32'h0,         32'h108,      0, 0, 7,  3);
    add(0, 0, 0, 0, 32'h0,        32'h100,      32'hA000_0040, 32'h100,      1, 1, 8,  3);
    add(0, 0, 0, 0, 32'h0,        32'h104,      32'hA000_0041, 32'h104,      1, 0, 9,  3);
    add(0, 0, 0, 1, 32'h0080_0000, 32'h108,     32'h0,         32'h108,      0, 0, 9,  4);
    add(0, 0, 0, 0, 32'h0,        32'h0080_0000, 32'hA020_0000, 32'h0080_0000, 1, 1, 10, 4);
    add(0, 0, 0, 1, 32'hFFFF_FFFC, 32'h0080_0004, 32'h0,       32'h0080_0004, 0, 0, 10, 5);
    add(0, 0, 0, 0, 32'h0,        32'hFFFF_FFFC, 32'hDFFF_FFFF, 32'hFFFF_FFFC, 1, 1, 11, 5);
    add(0, 0, 0, 0, 32'h0,        32'h0,        32'hA000_0000, 32'h0,        1, 0, 12, 5);
    add(1, 0, 0, 0, 32'h0,        32'h4,        32'hA000_0001, 32'h4,        1, 0, 13, 5);
    add(0, 0, 0, 0, 32'h0,        32'h4,        32'hA000_0001, 32'h4,        1, 0, 14, 5);

    reset = 1'b1;
    stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
    branch_taken_e = 1'b0; branch_target_e = 32'h0;
    @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      if (i != 0) @(negedge clk);
      stall_f = vq[i].sf; stall_d = vq[i].sd; flush_d = vq[i].fl;
      branch_taken_e = vq[i].br; branch_target_e = vq[i].tgt;
      #1;
      check($sformatf("v%0d_addr", i), imem_addr, vq[i].addr);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_instr", i), instr_d, vq[i].instr);
      check($sformatf("v%0d_pc", i), pc_d, vq[i].pc);
      check($sformatf("v%0d_valid", i), {31'h0, valid_d}, {31'h0, vq[i].valid});
      check($sformatf("v%0d_fault", i), {31'h0, fault_d}, {31'h0, vq[i].fault});
      check($sformatf("v%0d_fcount", i), fetch_count, vq[i].fc);
      check($sformatf("v%0d_bcount", i), bubble_count, vq[i].bc);
      if (vq[i].valid)
        check($sformatf("v%0d_pc4", i), pc_plus4_d, vq[i].pc + 32'd4);
    end

    // Asynchronous reset in the middle of a redirect cycle.
    @(negedge clk);
    stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
    branch_taken_e = 1'b1; branch_target_e = 32'h200;
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(posedge clk);
    #1;
    check_all_zero("rst_held");

    @(negedge clk);
    reset = 1'b0;
    branch_taken_e = 1'b0; branch_target_e = 32'h0;
    #1;
    check("post_rst_addr", imem_addr, 32'h0);
    @(posedge clk);
    #1;
    check("post_rst_instr", instr_d, 32'hA000_0000);
    check("post_rst_valid", {31'h0, valid_d}, 32'h1);
    check("post_rst_fcount", fetch_count, 32'h1);
    check("post_rst_bcount", bubble_count, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
